// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port req/ack memory between instruction fetch and the
// MEM stage, returning data with a one-cycle done pulse per requester.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_MEM,
        SERVE_IF
    } state_t;

    state_t            state, state_d;
    logic              last_mem, last_mem_d;
    logic              ram_req_d, ram_we_d, if_valid_d, mem_done_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d, if_rdata_d, mem_rdata_d;
    logic              mem_elig, if_elig;

    // A requester whose done pulse is high is completing and must not be regranted.
    assign mem_elig  = (mem_rd_req | mem_wr_req) & ~mem_done;
    assign if_elig   = if_req & ~if_valid;
    assign stall_mem = mem_elig;
    assign stall_if  = if_elig;

    always_comb begin
        state_d     = state;
        last_mem_d  = last_mem;
        ram_req_d   = ram_req;
        ram_we_d    = ram_we;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;
        if_valid_d  = 1'b0;
        mem_done_d  = 1'b0;

        case (state)
            IDLE: begin
                // On contention the side not granted last wins.
                if (mem_elig && (!if_elig || !last_mem)) begin
                    state_d     = SERVE_MEM;
                    last_mem_d  = 1'b1;
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_wr_req;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                end else if (if_elig) begin
                    state_d     = SERVE_IF;
                    last_mem_d  = 1'b0;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                end
            end
            SERVE_MEM: begin
                if (ram_ack) begin
                    state_d    = IDLE;
                    ram_req_d  = 1'b0;
                    ram_we_d   = 1'b0;
                    mem_done_d = 1'b1;
                    if (!ram_we) begin
                        mem_rdata_d = ram_rdata;
                    end
                end
            end
            SERVE_IF: begin
                if (ram_ack) begin
                    state_d    = IDLE;
                    ram_req_d  = 1'b0;
                    ram_we_d   = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last_mem  <= 1'b0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_valid  <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            state     <= state_d;
            last_mem  <= last_mem_d;
            ram_req   <= ram_req_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            if_rdata  <= if_rdata_d;
            mem_rdata <= mem_rdata_d;
            if_valid  <= if_valid_d;
            mem_done  <= mem_done_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction-level reference model
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_unified_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          mem_rd_req, mem_wr_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_done;
    logic          ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_ack;
    logic          stall_if, stall_mem;

    int passed = 0;
    int total  = 0;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference model: who holds the memory (0 none, 1 MEM, 2 IF) and what each
    // observable register must hold after the current edge.
    int          owner;
    bit          mem_went_last;
    logic        e_req, e_we, e_ifv, e_md;
    logic [31:0] e_addr, e_wdata, e_ifd, e_memd;

    always @(posedge clk) begin
        bit want_mem, want_if, nxt_ifv, nxt_md;
        nxt_ifv = 1'b0;
        nxt_md  = 1'b0;
        if (!rst) begin
            owner = 0; mem_went_last = 1'b0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_ifd = 0; e_memd = 0;
        end else if (owner == 0) begin
            want_mem = (mem_rd_req || mem_wr_req) && !e_md;
            want_if  = if_req && !e_ifv;
            if (want_mem && want_if) begin
                owner = mem_went_last ? 2 : 1;
            end else if (want_mem) begin
                owner = 1;
            end else if (want_if) begin
                owner = 2;
            end
            if (owner == 1) begin
                e_req = 1; e_we = mem_wr_req; e_addr = mem_addr; e_wdata = mem_wdata;
                mem_went_last = 1'b1;
            end else if (owner == 2) begin
                e_req = 1; e_we = 0; e_addr = if_addr; e_wdata = 0;
                mem_went_last = 1'b0;
            end
        end else if (ram_ack) begin
            if (owner == 1) begin
                if (!e_we) e_memd = ram_rdata;
                nxt_md = 1'b1;
            end else begin
                e_ifd = ram_rdata;
                nxt_ifv = 1'b1;
            end
            e_req = 0; e_we = 0; owner = 0;
        end
        e_ifv = nxt_ifv;
        e_md  = nxt_md;
    end

    always @(posedge clk) begin
        #2;
        check("ram_req",   64'(ram_req),   64'(e_req));
        check("ram_we",    64'(ram_we),    64'(e_we));
        check("ram_addr",  64'(ram_addr),  64'(e_addr));
        check("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
        check("if_valid",  64'(if_valid),  64'(e_ifv));
        check("if_rdata",  64'(if_rdata),  64'(e_ifd));
        check("mem_done",  64'(mem_done),  64'(e_md));
        check("mem_rdata", 64'(mem_rdata), 64'(e_memd));
        check("stall_if",  64'(stall_if),  64'(if_req && !e_ifv));
        check("stall_mem", 64'(stall_mem), 64'((mem_rd_req || mem_wr_req) && !e_md));
        check("one_done",  64'(if_valid && mem_done), 64'(0));
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h0000_1000; ram_ack = 1'b1;
        mem_rd_req = 0; mem_wr_req = 0; mem_addr = 0; mem_wdata = 0; ram_rdata = 0;

        // Reset held two cycles with request and ack asserted
        step(); step();
        check("rst_ram_req", 64'(ram_req), 64'(0));
        check("rst_if_valid", 64'(if_valid), 64'(0));
        rst = 1'b1; ram_ack = 1'b0;
        step();
        check("post_rst_req", 64'(ram_req), 64'(1));
        check("post_rst_addr", 64'(ram_addr), 64'(32'h0000_1000));
        ram_ack = 1'b1; ram_rdata = 32'hCAFE_0001;
        step();
        check("fetch_valid", 64'(if_valid), 64'(1));
        check("fetch_data", 64'(if_rdata), 64'(32'hCAFE_0001));
        ram_ack = 1'b0; if_req = 1'b0;
        step();

        // Single load, ack after three request cycles
        mem_rd_req = 1'b1; mem_addr = 32'h40;
        step();
        check("ld_req", 64'(ram_req), 64'(1));
        check("ld_we", 64'(ram_we), 64'(0));
        check("ld_addr", 64'(ram_addr), 64'(32'h40));
        step();
        step();
        check("ld_not_done", 64'(mem_done), 64'(0));
        ram_ack = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        step();
        check("ld_done", 64'(mem_done), 64'(1));
        check("ld_data", 64'(mem_rdata), 64'(32'hDEAD_BEEF));
        ram_ack = 1'b0; mem_rd_req = 1'b0;
        step();
        check("ld_done_pulse", 64'(mem_done), 64'(0));

        // Store with zero-wait ack
        mem_wr_req = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h1234_5678;
        step();
        check("st_we", 64'(ram_we), 64'(1));
        check("st_wdata", 64'(ram_wdata), 64'(32'h1234_5678));
        ram_ack = 1'b1; ram_rdata = 32'h5555_AAAA;
        step();
        check("st_done", 64'(mem_done), 64'(1));
        check("st_rdata_kept", 64'(mem_rdata), 64'(32'hDEAD_BEEF));
        ram_ack = 1'b0; mem_wr_req = 1'b0;
        step();

        // Contention right after reset: MEM first, then IF
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        if_req = 1'b1; if_addr = 32'h200; mem_rd_req = 1'b1; mem_addr = 32'h300;
        step();
        check("cont1_addr", 64'(ram_addr), 64'(32'h300));
        ram_ack = 1'b1; ram_rdata = 32'h0000_0333;
        step();
        check("cont1_mem_done", 64'(mem_done), 64'(1));
        ram_ack = 1'b0; mem_rd_req = 1'b0;
        step();
        check("cont1_if_req", 64'(ram_req), 64'(1));
        check("cont1_if_addr", 64'(ram_addr), 64'(32'h200));
        ram_ack = 1'b1; ram_rdata = 32'h0000_0222;
        step();
        check("cont1_if_valid", 64'(if_valid), 64'(1));
        check("cont1_if_data", 64'(if_rdata), 64'(32'h0000_0222));
        ram_ack = 1'b0; if_req = 1'b0;
        step();
        // Second contention: IF went last, so MEM wins again
        if_req = 1'b1; if_addr = 32'h204; mem_rd_req = 1'b1; mem_addr = 32'h304;
        step();
        check("cont2_addr", 64'(ram_addr), 64'(32'h304));
        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0; mem_rd_req = 1'b0;
        step();
        check("cont2_if_addr", 64'(ram_addr), 64'(32'h204));
        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0; if_req = 1'b0;
        step();

        // Reset in the middle of an IF access; the late ack is ignored
        if_req = 1'b1; if_addr = 32'h400;
        step();
        check("mid_req", 64'(ram_req), 64'(1));
        rst = 1'b0; if_req = 1'b0;
        step();
        check("mid_req_cleared", 64'(ram_req), 64'(0));
        rst = 1'b1;
        step();
        step();
        ram_ack = 1'b1; ram_rdata = 32'hBAD0_BAD0;
        step();
        check("mid_no_valid", 64'(if_valid), 64'(0));
        check("mid_no_req", 64'(ram_req), 64'(0));
        ram_ack = 1'b0;
        step();

        // Spurious ack while idle
        ram_ack = 1'b1; ram_rdata = 32'hFFFF_0000;
        step();
        ram_ack = 1'b0;
        check("spur_no_done", 64'(mem_done | if_valid), 64'(0));
        check("spur_no_req", 64'(ram_req), 64'(0));
        check("spur_if_data", 64'(if_rdata), 64'(0));
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw driven from the EXE/MEM pipeline register). It serialises requests, drives a variable-latency req/ack memory port, returns read data with a one-cycle done pulse per requester and generates the stall signals that freeze the pipeline registers while an access is outstanding.

## Interface
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (sampled on the rising edge of clk)
- if_req  in  1  IF requests an instruction read; held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction; valid when if_valid=1
- if_valid  out  1  one-cycle pulse: fetch complete
- mem_rd_req  in  1  MEM-stage load request (EXE/MEM mem_read)
- mem_wr_req  in  1  MEM-stage store request (EXE/MEM mem_write); rd and wr never both 1
- mem_addr  in  ADDR_W  load/store address (EXE/MEM ALU result)
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid when mem_done=1
- mem_done  out  1  one-cycle pulse: load/store complete
- ram_req  out  1  memory request, held until ram_ack sampled
- ram_we  out  1  1=write, 0=read; stable while ram_req=1
- ram_addr  out  ADDR_W  memory address; stable while ram_req=1
- ram_wdata  out  DATA_W  memory write data; stable while ram_req=1
- ram_rdata  in  DATA_W  memory read data; valid in the ack cycle
- ram_ack  in  1  memory completion, one cycle
- stall_if  out  1  freeze PC and IF/ID register
- stall_mem  out  1  freeze everything up to and including EXE/MEM

## Operation
- FSM states: IDLE, SERVE_MEM, SERVE_IF.
- Eligibility in IDLE: MEM eligible iff (mem_rd_req|mem_wr_req) & ~mem_done; IF eligible iff if_req & ~if_valid (a requester whose done pulse is high this cycle is completing and is not regranted).
- Arbitration in IDLE: only one eligible → grant it. Both eligible → grant the one not granted last (last_grant flag; reset value IF, so MEM wins the first contention).
- On grant: latch address, we (mem_wr_req for MEM, 0 for IF) and wdata (mem_wdata or 0) into output registers; set ram_req=1; update last_grant; move to SERVE_MEM/SERVE_IF.
- In SERVE_*: hold ram_req and latched fields; ignore requester inputs. On ram_ack=1: ram_req←0, ram_we←0; for reads capture ram_rdata into mem_rdata or if_rdata; pulse the matching done (mem_done/if_valid) next cycle; go to IDLE.
- Stores: mem_rdata unchanged; mem_done still pulses.
- ram_ack in IDLE is ignored (no state or output change).
- stall_if = if_req & ~if_valid; stall_mem = (mem_rd_req|mem_wr_req) & ~mem_done (combinational). stall_mem also drives stall_if externally via pipeline control; this block does not combine them.
- Reset (rst=0 at edge), any state: state←IDLE, last_grant←IF; ram_req, ram_we, if_valid, mem_done←0; ram_addr, ram_wdata, if_rdata, mem_rdata←0. An outstanding access is abandoned; a later ram_ack is ignored.

## Timing
- Grant decision in cycle t (IDLE) → ram_req=1 from t+1.
- ram_ack sampled at cycle t+k (k≥1) → done pulse and data at t+k+1, state IDLE at t+k+1.
- Minimum request-to-done latency: 2 cycles + memory wait states; zero-wait memory (ack at t+1) gives done at t+2.
- Next grant earliest in the done cycle (t+k+1) for the other requester; ram_req again at t+k+2. One idle ram cycle between accesses.
- Done pulses are exactly one cycle; if_valid and mem_done never both 1.

## Test plan
- Reset: hold rst=0 two cycles with if_req=1, ram_ack=1 → all outputs 0, ram_req stays 0 until one cycle after rst=1.
- Single load: mem_rd_req=1, mem_addr=0x40 at cycle 0, ram_ack at cycle 3 with ram_rdata=0xDEADBEEF → ram_req=1, ram_we=0, ram_addr=0x40 cycles 1–3; mem_done=1, mem_rdata=0xDEADBEEF cycle 4 only; stall_mem=1 cycles 0–3.
- Store: mem_wr_req=1, addr 0x80, wdata 0x12345678, zero-wait ack → ram_we=1 cycle 1, mem_done cycle 2, mem_rdata unchanged.
- Contention: after reset if_req and mem_rd_req both 1, zero-wait memory → MEM served first (done cycle 2), IF served next (ram_req cycle 3, if_valid cycle 4); next simultaneous contention grants MEM again.
- Reset mid-access: rst=0 while SERVE_IF with ram_req=1, ram_ack arrives two cycles after rst=1 with no requests → ram_req=0 after reset edge, no if_valid pulse, state IDLE.
- Spurious ack: ram_ack=1 in IDLE with no requests → no done pulse, ram_req stays 0.
